// File: rtl/uart_recv_pkg.sv
// uart_recv_pkg: shared UART bit-timing helpers and receiver state encoding.
package uart_recv_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam int DATA_BITS_DEF = 8;
  function automatic int baud_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction
endpackage

// File: rtl/uart_recv_sync_2ff.sv
// uart_recv_sync_2ff: two-stage synchronizer that resets to the idle-high line level.
module uart_recv_sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);
  logic s1_q, s2_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end
  assign q_o = s2_q;
endmodule

// File: rtl/uart_recv.sv
// uart_recv: 8N1 UART receiver sampling mid-bit, one-cycle valid/frame_err pulses.
module uart_recv
  import uart_recv_pkg::*;
#(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD      = 9600,
  parameter int DATA_BITS = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 din,
  output logic                 valid,
  output logic [DATA_BITS-1:0] data,
  output logic                 frame_err,
  output logic                 busy
);
  localparam int BAUD_CNT = baud_div(CLK_FREQ, BAUD);
  localparam int HALF_CNT = BAUD_CNT / 2;
  localparam int CW = $clog2(BAUD_CNT + 1);
  localparam int BW = $clog2(DATA_BITS + 1);
  state_t state_q, state_d;
  logic cur, prev_q, fall, half_hit, full_hit, last_bit, stop_hit;
  logic [CW-1:0] baud_q, baud_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d, data_q, data_d;
  logic valid_q, valid_d, ferr_q, ferr_d;
  uart_recv_sync_2ff u_sync (.clk(clk), .rst(rst), .d_i(din), .q_o(cur));
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      prev_q  <= 1'b1;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= cur;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end
  assign fall     = prev_q & ~cur;
  assign half_hit = baud_q == CW'(HALF_CNT - 1);
  assign full_hit = baud_q == CW'(BAUD_CNT - 1);
  assign last_bit = bit_q == BW'(DATA_BITS - 1);
  assign stop_hit = (state_q == STOP) && full_hit;
  // A high level at mid-start-bit is treated as a glitch and drops back to IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = fall ? START : IDLE;
      START:   state_d = half_hit ? (cur ? IDLE : DATA) : START;
      DATA:    state_d = (full_hit && last_bit) ? STOP : DATA;
      STOP:    state_d = full_hit ? IDLE : STOP;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    baud_d  = (state_q == IDLE || state_d != state_q || full_hit) ? '0 : baud_q + CW'(1);
    bit_d   = (state_q != DATA) ? '0 : full_hit ? bit_q + BW'(1) : bit_q;
    shreg_d = (state_q == DATA && full_hit) ? {cur, shreg_q[DATA_BITS-1:1]} : shreg_q;
    valid_d = stop_hit & cur;
    ferr_d  = stop_hit & ~cur;
    data_d  = valid_d ? shreg_q : data_q;
  end
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign data      = data_q;
  assign busy      = state_q != IDLE;
endmodule

// File: tb/tb_uart_recv.sv
// tb_uart_recv: directed and randomized frames checked against a byte-level line model.
module tb_uart_recv;
  localparam int BC = 10;
  logic clk = 1'b0, rst = 1'b1, din = 1'b1;
  logic valid, frame_err, busy;
  logic [7:0] data;
  int cyc = 0, n_chk = 0, n_fail = 0;
  int valid_cnt = 0, ferr_cnt = 0, both_cnt = 0, long_cnt = 0, vcyc = 0, fall_cyc = 0;
  int exp_ferr = 0;
  logic [7:0] last_good = 8'h00;
  logic [7:0] rx_q[$], exp_q[$];
  logic pv = 1'b0, pf = 1'b0;

  uart_recv #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8)) dut (
    .clk(clk), .rst(rst), .din(din), .valid(valid), .data(data),
    .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (valid) begin
      rx_q.push_back(data);
      valid_cnt++;
      vcyc = cyc;
    end
    if (frame_err) ferr_cnt++;
    if (valid && frame_err) both_cnt++;
    if ((valid && pv) || (frame_err && pf)) long_cnt++;
    pv = valid;
    pf = frame_err;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Line model: a frame is start(0), LSB-first bits, stop; each bit lasts BC clocks.
  task automatic send(input logic [7:0] b, input logic stop);
    din = 1'b0;
    fall_cyc = cyc;
    idle(BC);
    for (int i = 0; i < 8; i++) begin
      din = b[i];
      idle(BC);
    end
    din = stop;
    if (stop) begin
      exp_q.push_back(b);
      last_good = b;
    end else exp_ferr++;
    idle(BC);
    din = 1'b1;
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() > 0) begin
      if (rx_q.size() == 0) begin
        chk({tag, "_missing"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
      end else chk(tag, 32'(rx_q.pop_front()), 32'(exp_q.pop_front()));
    end
    chk({tag, "_extra"}, 32'(rx_q.size()), 32'd0);
    rx_q.delete();
  endtask

  initial begin
    int v0, lat;
    logic [7:0] b;
    idle(3);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_ferr", 32'(frame_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    idle(5);
    send(8'h55, 1'b1);
    idle(15);
    lat = vcyc - fall_cyc;
    chk("t1_lat_ok", 32'(lat >= 97 && lat <= 99), 32'd1);
    chk("t1_vcnt", 32'(valid_cnt), 32'd1);
    chk("t1_data", 32'(data), 32'h55);
    chk("t1_ferr", 32'(ferr_cnt), 32'(exp_ferr));
    chk("t1_busy", 32'(busy), 32'd0);
    drain("t1_byte");
    send(8'hA3, 1'b1);
    send(8'h0F, 1'b1);
    idle(15);
    chk("t2_vcnt", 32'(valid_cnt), 32'd3);
    drain("t2_byte");
    v0 = valid_cnt;
    din = 1'b0;
    idle(3);
    din = 1'b1;
    idle(1);
    chk("t3_busy_hi", 32'(busy), 32'd1);
    idle(8);
    chk("t3_busy_lo", 32'(busy), 32'd0);
    idle(10);
    chk("t3_vcnt", 32'(valid_cnt), 32'(v0));
    chk("t3_ferr", 32'(ferr_cnt), 32'(exp_ferr));
    send(8'h3C, 1'b0);
    din = 1'b0;
    idle(30);
    chk("t4_ferr", 32'(ferr_cnt), 32'(exp_ferr));
    chk("t4_vcnt", 32'(valid_cnt), 32'(v0));
    chk("t4_data", 32'(data), 32'(last_good));
    chk("t4_noretrig", 32'(busy), 32'd0);
    din = 1'b1;
    idle(20);
    din = 1'b0;
    idle(BC);
    din = 1'b1;
    idle(45);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    last_good = 8'h00;
    chk("t5_valid", 32'(valid), 32'd0);
    chk("t5_data", 32'(data), 32'(last_good));
    chk("t5_ferr", 32'(frame_err), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    idle(60);
    chk("t5_vcnt", 32'(valid_cnt), 32'(v0));
    send(8'h81, 1'b1);
    idle(15);
    chk("t5_data2", 32'(data), 32'h81);
    drain("t5_byte");
    v0 = valid_cnt;
    for (int i = 0; i < 256; i++) begin
      send(8'(i), 1'b1);
      idle(BC * $urandom_range(0, 3));
    end
    idle(15);
    chk("t6_vcnt", 32'(valid_cnt - v0), 32'd256);
    drain("t6_byte");
    v0 = valid_cnt;
    for (int i = 0; i < 20; i++) begin
      b = 8'($urandom);
      send(b, 1'($urandom_range(0, 4) != 0));
      idle(BC + BC * $urandom_range(0, 2));
    end
    idle(15);
    chk("t7_ferr", 32'(ferr_cnt), 32'(exp_ferr));
    chk("t7_data", 32'(data), 32'(last_good));
    drain("t7_byte");
    chk("excl_pulses", 32'(both_cnt), 32'd0);
    chk("pulse_width", 32'(long_cnt), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
